// File: rtl/gtxe2_chnl_cpll_lockdet_pkg.sv
// CPLL lock detector shared definitions.
// State encodings, default window constants, band check.
package gtxe2_chnl_cpll_lockdet_pkg;

    typedef enum logic [1:0] {
        GTXE2_CHNL_CPLL_LOCKDET_IDLE    = 2'd0,
        GTXE2_CHNL_CPLL_LOCKDET_ACQUIRE = 2'd1,
        GTXE2_CHNL_CPLL_LOCKDET_LOCKED  = 2'd2
    } lockdet_st_t;

    localparam int LOCKDET_WINDOW         = 256;
    localparam int LOCKDET_EXPECTED       = 128;
    localparam int LOCKDET_TOL            = 4;
    localparam int LOCKDET_LOCK_WINDOWS   = 4;
    localparam int LOCKDET_UNLOCK_WINDOWS = 2;

    // Lower bound clamps at zero when tol exceeds expv.
    function automatic logic in_band(int cnt, int expv, int tol);
        int lo;
        lo = (expv > tol) ? expv - tol : 0;
        return (cnt >= lo) && (cnt <= expv + tol);
    endfunction

endpackage

// File: rtl/gtxe2_chnl_cpll_lockdet_fbsync.sv
// Feedback toggle synchronizer and edge detector.
// Any change of the synchronized level is one transition.
module gtxe2_chnl_cpll_fbsync
    import gtxe2_chnl_cpll_lockdet_pkg::*;
(
    input  logic ref_clk,
    input  logic reset,
    input  logic fb_tgl,
    output logic fb_edge
);

    logic s1;
    logic s2;
    logic s3;

    // Two sync flops plus one history flop for edge compare.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= fb_tgl;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fb_edge = s2 ^ s3;

endmodule

// File: rtl/gtxe2_chnl_cpll_lockdet.sv
// CPLL frequency lock detector.
// Counts feedback transitions per window, qualifies lock with hysteresis.
module gtxe2_chnl_cpll_lockdet
    import gtxe2_chnl_cpll_lockdet_pkg::*;
#(
    parameter int WINDOW         = LOCKDET_WINDOW,
    parameter int EXPECTED       = LOCKDET_EXPECTED,
    parameter int TOL            = LOCKDET_TOL,
    parameter int LOCK_WINDOWS   = LOCKDET_LOCK_WINDOWS,
    parameter int UNLOCK_WINDOWS = LOCKDET_UNLOCK_WINDOWS,
    parameter int CNT_W          = $clog2(WINDOW + 1)
) (
    input  logic             ref_clk,
    input  logic             reset,
    input  logic             lockdet_en,
    input  logic             fb_tgl,
    output logic             lock,
    output logic             fbclk_lost,
    output logic [CNT_W-1:0] win_count,
    output logic             win_valid
);

    localparam int GR_W = $clog2(LOCK_WINDOWS + 1);
    localparam int BR_W = $clog2(UNLOCK_WINDOWS + 1);

    lockdet_st_t      st;
    logic [CNT_W-1:0] win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [GR_W-1:0]  good_run;
    logic [BR_W-1:0]  bad_run;

    logic             fb_edge;
    logic [CNT_W-1:0] count_now;
    logic             eval;
    logic             zero;
    logic             good;

    gtxe2_chnl_cpll_fbsync u_fbsync (
        .ref_clk (ref_clk),
        .reset   (reset),
        .fb_tgl  (fb_tgl),
        .fb_edge (fb_edge)
    );

    // Saturating count including this cycle's edge, and window verdict.
    always_comb begin
        count_now = edge_cnt;
        if (fb_edge && (edge_cnt != '1)) begin
            count_now = edge_cnt + CNT_W'(1);
        end
        eval = (win_cnt == CNT_W'(WINDOW - 1));
        zero = (count_now == '0);
        good = in_band(int'(count_now), EXPECTED, TOL) && !zero;
    end

    // Window sequencing and lock qualification state machine.
    always_ff @(posedge ref_clk or posedge reset) begin
        if (reset) begin
            st         <= GTXE2_CHNL_CPLL_LOCKDET_IDLE;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            lock       <= 1'b0;
            fbclk_lost <= 1'b0;
            win_count  <= '0;
            win_valid  <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (!lockdet_en) begin
                st         <= GTXE2_CHNL_CPLL_LOCKDET_IDLE;
                win_cnt    <= '0;
                edge_cnt   <= '0;
                good_run   <= '0;
                bad_run    <= '0;
                lock       <= 1'b0;
                fbclk_lost <= 1'b0;
            end else begin
                unique case (st)
                    GTXE2_CHNL_CPLL_LOCKDET_IDLE: begin
                        st <= GTXE2_CHNL_CPLL_LOCKDET_ACQUIRE;
                    end
                    GTXE2_CHNL_CPLL_LOCKDET_ACQUIRE,
                    GTXE2_CHNL_CPLL_LOCKDET_LOCKED: begin
                        if (!eval) begin
                            win_cnt  <= win_cnt + CNT_W'(1);
                            edge_cnt <= count_now;
                        end else begin
                            win_cnt    <= '0;
                            edge_cnt   <= '0;
                            win_count  <= count_now;
                            fbclk_lost <= zero;
                            win_valid  <= 1'b1;
                            if (st == GTXE2_CHNL_CPLL_LOCKDET_LOCKED) begin
                                if (zero || (!good &&
                                    int'(bad_run) + 1 >= UNLOCK_WINDOWS)) begin
                                    st       <= GTXE2_CHNL_CPLL_LOCKDET_ACQUIRE;
                                    lock     <= 1'b0;
                                    good_run <= '0;
                                    bad_run  <= '0;
                                end else if (!good) begin
                                    bad_run <= bad_run + BR_W'(1);
                                end else begin
                                    bad_run <= '0;
                                end
                            end else begin
                                if (!good) begin
                                    good_run <= '0;
                                end else if (int'(good_run) + 1
                                             >= LOCK_WINDOWS) begin
                                    st       <= GTXE2_CHNL_CPLL_LOCKDET_LOCKED;
                                    lock     <= 1'b1;
                                    good_run <= '0;
                                    bad_run  <= '0;
                                end else begin
                                    good_run <= good_run + GR_W'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        st <= GTXE2_CHNL_CPLL_LOCKDET_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gtxe2_chnl_cpll_lockdet.sv
// Bench for the CPLL lock detector.
// Window-aligned toggle generator with an expected-result queue.
module tb_gtxe2_chnl_cpll_lockdet;
    import gtxe2_chnl_cpll_lockdet_pkg::*;

    localparam int W  = 256;
    localparam int LO = LOCKDET_EXPECTED - LOCKDET_TOL;
    localparam int HI = LOCKDET_EXPECTED + LOCKDET_TOL;

    logic       ref_clk = 1'b0;
    logic       reset = 1'b1;
    logic       lockdet_en = 1'b0;
    logic       fb_tgl = 1'b0;
    logic       lock;
    logic       fbclk_lost;
    logic [8:0] win_count;
    logic       win_valid;

    typedef struct {
        int   idx;
        int   cnt;
        logic lk;
        logic lost;
    } exp_t;

    exp_t exp_q[$];
    int   rates[$];

    int checks = 0;
    int failures = 0;

    bit gen_on = 1'b0;
    bit park = 1'b0;
    int epoch = 0;
    int seen_epoch = 0;
    int gen_k = 0;
    int cur_n = 128;
    int gen_win = 0;
    int last_rate_win = 0;
    int last_idx = 0;
    int m_good = 0;
    int m_bad = 0;
    bit m_locked = 1'b0;

    always #5 ref_clk = ~ref_clk;

    gtxe2_chnl_cpll_lockdet dut (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .lockdet_en (lockdet_en),
        .fb_tgl     (fb_tgl),
        .lock       (lock),
        .fbclk_lost (fbclk_lost),
        .win_count  (win_count),
        .win_valid  (win_valid)
    );

    // Generator, reference model and scoreboard, all on the falling edge.
    always @(negedge ref_clk) begin : sb_gen
        exp_t e;
        bit   good;
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            gen_k = 0;
            exp_q.delete();
            m_good = 0;
            m_bad = 0;
            m_locked = 1'b0;
        end
        if (win_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_win_valid got count=%0d want none",
                         win_count);
            end else begin
                e = exp_q.pop_front();
                last_idx = e.idx;
                if (win_count !== 9'(e.cnt) || lock !== e.lk ||
                    fbclk_lost !== e.lost) begin
                    failures++;
                    $display("FAIL window%0d got count=%0d lock=%b lost=%b want count=%0d lock=%b lost=%b",
                             e.idx, win_count, lock, fbclk_lost,
                             e.cnt, e.lk, e.lost);
                end
            end
        end
        if (!gen_on) begin
            if (park) fb_tgl = 1'b0;
        end else begin
            if (gen_k == 0) begin
                if (rates.size() > 0) begin
                    cur_n = rates.pop_front();
                    last_rate_win = gen_win + 1;
                end else begin
                    cur_n = 128;
                end
                gen_win++;
                good = (cur_n >= LO) && (cur_n <= HI) && (cur_n != 0);
                if (!m_locked) begin
                    if (good) begin
                        m_good++;
                        if (m_good == LOCKDET_LOCK_WINDOWS) begin
                            m_locked = 1'b1;
                            m_good = 0;
                            m_bad = 0;
                        end
                    end else begin
                        m_good = 0;
                    end
                end else if (cur_n == 0) begin
                    m_locked = 1'b0;
                    m_good = 0;
                    m_bad = 0;
                end else if (!good) begin
                    m_bad++;
                    if (m_bad == LOCKDET_UNLOCK_WINDOWS) begin
                        m_locked = 1'b0;
                        m_good = 0;
                        m_bad = 0;
                    end
                end else begin
                    m_bad = 0;
                end
                e.idx = gen_win;
                e.cnt = cur_n;
                e.lk = m_locked;
                e.lost = (cur_n == 0);
                exp_q.push_back(e);
            end
            if (gen_k >= 8 && gen_k < 248 &&
                ((gen_k - 7) * cur_n / 240) != ((gen_k - 8) * cur_n / 240))
                fb_tgl = ~fb_tgl;
            gen_k = (gen_k + 1) % W;
        end
    end

    task automatic start_enable();
        @(posedge ref_clk);
        #2;
        lockdet_en = 1'b1;
        epoch++;
        gen_on = 1'b1;
    endtask

    task automatic stop_enable();
        @(posedge ref_clk);
        #2;
        lockdet_en = 1'b0;
        gen_on = 1'b0;
        epoch++;
    endtask

    task automatic wait_lock(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(posedge ref_clk);
            n++;
            #1;
            if (lock === 1'b1) break;
        end
    endtask

    task automatic wait_rates_done(input int limit);
        int c;
        c = 0;
        while ((rates.size() > 0 || last_idx < last_rate_win) && c < limit) begin
            @(posedge ref_clk);
            c++;
        end
        #1;
        if (c >= limit) begin
            checks++;
            failures++;
            $display("FAIL rates_timeout got %0d cycles want < %0d", c, limit);
        end
    endtask

    task automatic wait_next_window(input int limit);
        int c;
        int t;
        c = 0;
        t = last_idx;
        while (last_idx <= t && c < limit) begin
            @(posedge ref_clk);
            c++;
        end
        #1;
        if (c >= limit) begin
            checks++;
            failures++;
            $display("FAIL window_timeout got %0d cycles want < %0d", c, limit);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (lock !== 1'b0) begin
            failures++;
            $display("FAIL reset_lock got %b want 0", lock);
        end
        checks++;
        if (fbclk_lost !== 1'b0) begin
            failures++;
            $display("FAIL reset_lost got %b want 0", fbclk_lost);
        end
        checks++;
        if (win_count !== 9'd0) begin
            failures++;
            $display("FAIL reset_count got %0d want 0", win_count);
        end
        checks++;
        if (win_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got %b want 0", win_valid);
        end
        @(posedge ref_clk);
        #2;
        reset = 1'b0;
        repeat (3) @(posedge ref_clk);
        #1;
        checks++;
        if (lock !== 1'b0 || win_valid !== 1'b0) begin
            failures++;
            $display("FAIL disabled_idle got lock=%b valid=%b want 0 0",
                     lock, win_valid);
        end
    endtask

    task automatic test_nominal_lock();
        int n;
        start_enable();
        wait_lock(3000, n);
        checks++;
        if (n !== 1025) begin
            failures++;
            $display("FAIL nominal_latency got %0d want 1025", n);
        end
        wait_next_window(600);
        checks++;
        if (lock !== 1'b1 || win_count !== 9'd128) begin
            failures++;
            $display("FAIL nominal_hold got lock=%b count=%0d want 1 128",
                     lock, win_count);
        end
    endtask

    task automatic test_hysteresis();
        int n;
        rates.push_back(140);
        wait_rates_done(1200);
        checks++;
        if (lock !== 1'b1 || win_count !== 9'd140) begin
            failures++;
            $display("FAIL hyst_single got lock=%b count=%0d want 1 140",
                     lock, win_count);
        end
        wait_next_window(600);
        checks++;
        if (lock !== 1'b1 || win_count !== 9'd128) begin
            failures++;
            $display("FAIL hyst_recover got lock=%b count=%0d want 1 128",
                     lock, win_count);
        end
        rates.push_back(140);
        rates.push_back(140);
        wait_rates_done(1500);
        checks++;
        if (lock !== 1'b0 || win_count !== 9'd140) begin
            failures++;
            $display("FAIL hyst_drop got lock=%b count=%0d want 0 140",
                     lock, win_count);
        end
        wait_lock(1500, n);
        checks++;
        if (lock !== 1'b1) begin
            failures++;
            $display("FAIL hyst_relock got lock=%b want 1", lock);
        end
    endtask

    task automatic test_fb_loss();
        int n;
        rates.push_back(0);
        wait_rates_done(1200);
        checks++;
        if (lock !== 1'b0 || fbclk_lost !== 1'b1 || win_count !== 9'd0) begin
            failures++;
            $display("FAIL loss got lock=%b lost=%b count=%0d want 0 1 0",
                     lock, fbclk_lost, win_count);
        end
        wait_next_window(600);
        checks++;
        if (fbclk_lost !== 1'b0 || win_count !== 9'd128) begin
            failures++;
            $display("FAIL loss_clear got lost=%b count=%0d want 0 128",
                     fbclk_lost, win_count);
        end
        wait_lock(1500, n);
        checks++;
        if (lock !== 1'b1) begin
            failures++;
            $display("FAIL loss_relock got lock=%b want 1", lock);
        end
    endtask

    task automatic test_tolerance();
        int n;
        stop_enable();
        repeat (5) @(posedge ref_clk);
        rates.push_back(124);
        rates.push_back(132);
        rates.push_back(123);
        start_enable();
        wait_lock(2500, n);
        checks++;
        if (n !== 1793) begin
            failures++;
            $display("FAIL tol_latency got %0d want 1793", n);
        end
    endtask

    task automatic test_enable_toggle();
        int n;
        int vcnt;
        repeat (128) @(posedge ref_clk);
        stop_enable();
        @(posedge ref_clk);
        #1;
        checks++;
        if (lock !== 1'b0) begin
            failures++;
            $display("FAIL en_drop got lock=%b want 0", lock);
        end
        vcnt = 0;
        repeat (9) begin
            @(posedge ref_clk);
            #1;
            if (win_valid === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin
            failures++;
            $display("FAIL en_no_valid got %0d pulses want 0", vcnt);
        end
        #1;
        lockdet_en = 1'b1;
        epoch++;
        gen_on = 1'b1;
        wait_lock(3000, n);
        checks++;
        if (n !== 1025) begin
            failures++;
            $display("FAIL en_relock got %0d want 1025", n);
        end
    endtask

    task automatic test_async_reset();
        int n;
        repeat (100) @(posedge ref_clk);
        #2;
        gen_on = 1'b0;
        park = 1'b1;
        repeat (3) @(posedge ref_clk);
        #1;
        checks++;
        if (lock !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre got lock=%b want 1", lock);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (lock !== 1'b0 || fbclk_lost !== 1'b0 ||
            win_count !== 9'd0 || win_valid !== 1'b0) begin
            failures++;
            $display("FAIL arst got lock=%b lost=%b count=%0d valid=%b want 0 0 0 0",
                     lock, fbclk_lost, win_count, win_valid);
        end
        #1;
        reset = 1'b0;
        park = 1'b0;
        epoch++;
        gen_on = 1'b1;
        wait_lock(3000, n);
        checks++;
        if (n !== 1025) begin
            failures++;
            $display("FAIL arst_relock got %0d want 1025", n);
        end
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_hysteresis();
        test_fb_loss();
        test_tolerance();
        test_enable_toggle();
        test_async_reset();
        repeat (4) @(posedge ref_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
